// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: the serial adder state encoding and
// helpers for sizing its bit counter.
package arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } serial_add_state_t;

    // Counter width for a WIDTH-step sequence; never narrower than one bit.
    function automatic int cnt_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the one arithmetic slice the serial adder reuses
// every cycle.
module FullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_p;

    assign w_p    = i_a ^ i_b;
    assign o_sum  = w_p ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule

// File: rtl/bit_serial_adder.sv
// WIDTH-bit adder that processes one bit per clock, LSB first, through a single
// FullAdder, with valid/ready handshakes on both the operand and result sides.
module bit_serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int              CW   = cnt_bits(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    serial_add_state_t r_state;
    logic [WIDTH-1:0]  r_a_sr;
    logic [WIDTH-1:0]  r_b_sr;
    logic [WIDTH-1:0]  r_sum_sr;
    logic              r_carry;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;

    logic              w_fa_sum;
    logic              w_fa_cout;
    logic [WIDTH-1:0]  w_sum_next;

    FullAdder u_fa (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign w_sum_next = {w_fa_sum, r_sum_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_sum_sr    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sr     <= a;
                        r_b_sr     <= b;
                        r_carry    <= cin;
                        r_cnt      <= '0;
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_sum_sr <= w_sum_next;
                    r_carry  <= w_fa_cout;
                    if (r_cnt == LAST) begin
                        // Counter parks at zero rather than wrapping past LAST.
                        r_cnt       <= '0;
                        r_sum       <= w_sum_next;
                        r_cout      <= w_fa_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    // in_valid is deliberately ignored here; handoff only.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign busy      = r_busy;

endmodule
